// File: rtl/key_debounce_pkg.sv
// Shared types and sizing helpers for the front-panel key conditioner.
package key_debounce_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    GAP,
    RELEASE_WAIT
  } kd_state_t;

  // Counter width able to hold 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int rep_width(input int delay, input int period);
    return cnt_width((delay > period) ? delay : period);
  endfunction

endpackage

// File: rtl/key_debounce_chan.sv
// One key channel: 2-flop synchronizer, debounce/auto-repeat FSM and
// registered outputs decoded from the next state.
module key_debounce_chan
  import key_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000,
  parameter bit REPEAT_EN       = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key_raw_n,
  output logic key_out,
  output logic key_level
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
  localparam int REP_W = rep_width(REPEAT_DELAY, REPEAT_PERIOD);

  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [REP_W-1:0] DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);
  localparam logic [REP_W-1:0] REP_MAX     = '1;

  logic             sync_meta;
  logic             sync;
  kd_state_t        state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [REP_W-1:0] rep, rep_nx;
  logic             rep_first, rep_first_nx;
  logic [REP_W-1:0] rep_target;

  // The first repeat waits the long delay; later ones use the period.
  assign rep_target = rep_first ? DELAY_LAST : PERIOD_LAST;

  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    rep_nx       = rep;
    rep_first_nx = rep_first;
    unique case (state)
      IDLE: begin
        if (sync) begin
          state_nx = PRESS_WAIT;
          cnt_nx   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!sync) begin
          state_nx = IDLE;
        end else if (cnt == CNT_LAST) begin
          state_nx     = HELD;
          rep_nx       = '0;
          rep_first_nx = 1'b1;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      HELD: begin
        if (!sync) begin
          state_nx = RELEASE_WAIT;
          cnt_nx   = '0;
        end else if (REPEAT_EN && (rep == rep_target)) begin
          state_nx     = GAP;
          rep_nx       = '0;
          rep_first_nx = 1'b0;
        end else if (rep != REP_MAX) begin
          rep_nx = rep + REP_W'(1);
        end
      end
      GAP: begin
        // The gap cycle counts toward the next period.
        rep_nx = rep + REP_W'(1);
        if (sync) begin
          state_nx = HELD;
        end else begin
          state_nx = RELEASE_WAIT;
          cnt_nx   = '0;
        end
      end
      RELEASE_WAIT: begin
        // A bounce back to pressed resumes the frozen repeat schedule.
        if (sync) begin
          state_nx = HELD;
        end else if (cnt == CNT_LAST) begin
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_meta <= 1'b0;
      sync      <= 1'b0;
      state     <= IDLE;
      cnt       <= '0;
      rep       <= '0;
      rep_first <= 1'b1;
      key_out   <= 1'b0;
      key_level <= 1'b0;
    end else begin
      sync_meta <= ~key_raw_n;
      sync      <= sync_meta;
      state     <= state_nx;
      cnt       <= cnt_nx;
      rep       <= rep_nx;
      rep_first <= rep_first_nx;
      key_level <= (state_nx == HELD) || (state_nx == GAP) ||
                   (state_nx == RELEASE_WAIT);
      key_out   <= (state_nx == HELD) || (state_nx == RELEASE_WAIT);
    end
  end

endmodule

// File: rtl/key_debounce.sv
// Front-panel key conditioner: WIDTH independent debounce/auto-repeat
// channels feeding the processor PIO in_port.
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int               WIDTH           = 5,
  parameter int               DEBOUNCE_CYCLES = 500000,
  parameter int               REPEAT_DELAY    = 25000000,
  parameter int               REPEAT_PERIOD   = 5000000,
  parameter logic [WIDTH-1:0] REPEAT_MASK     = 5'b00011
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] key_raw_n,
  output logic [WIDTH-1:0] key_out,
  output logic [WIDTH-1:0] key_level
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    key_debounce_chan #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD),
      .REPEAT_EN       (REPEAT_MASK[i])
    ) u_chan (
      .clk       (clk),
      .reset_n   (reset_n),
      .key_raw_n (key_raw_n[i]),
      .key_out   (key_out[i]),
      .key_level (key_level[i])
    );
  end

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with short debounce/repeat timings and
// a same-clock PIO rising-edge capture model.
module tb_key_debounce;

  localparam int W   = 5;
  localparam int DB  = 4;
  localparam int DLY = 20;
  localparam int PER = 8;

  logic         clk;
  logic         reset_n;
  logic [W-1:0] key_raw_n;
  logic [W-1:0] key_out;
  logic [W-1:0] key_level;

  logic [W-1:0] pio_prev;
  logic [W-1:0] edge_capture;
  logic         ec_clr;

  int passed = 0;
  int total  = 0;

  key_debounce #(
    .WIDTH           (W),
    .DEBOUNCE_CYCLES (DB),
    .REPEAT_DELAY    (DLY),
    .REPEAT_PERIOD   (PER),
    .REPEAT_MASK     (5'b00001)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .key_raw_n (key_raw_n),
    .key_out   (key_out),
    .key_level (key_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PIO in_port rising-edge capture, cleared by the ISR stand-in.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pio_prev     <= '0;
      edge_capture <= '0;
    end else begin
      pio_prev     <= key_out;
      edge_capture <= (ec_clr ? '0 : edge_capture) | (key_out & ~pio_prev);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    logic exp_out;
    int   sets;
    reset_n   = 1'b0;
    key_raw_n = '1;
    ec_clr    = 1'b0;

    // reset state
    step(2);
    check("reset_out", 32'(key_out), 32'h0);
    check("reset_level", 32'(key_level), 32'h0);
    reset_n = 1'b1;
    step(3);
    check("idle_out", 32'(key_out), 32'h0);

    // clean press on channel 2: rises on the 7th edge
    key_raw_n[2] = 1'b0;
    step(6);
    check("press2_pre", 32'(key_out), 32'h0);
    step(1);
    check("press2_out", 32'(key_out), 32'h04);
    check("press2_level", 32'(key_level), 32'h04);

    // release glitch while held: output must not move
    step(3);
    key_raw_n[2] = 1'b1;
    step(2);
    key_raw_n[2] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step(1);
      check("glitch2_out", 32'(key_out), 32'h04);
      check("glitch2_level", 32'(key_level), 32'h04);
    end

    // clean release: falls on the 7th edge
    key_raw_n[2] = 1'b1;
    step(6);
    check("release2_pre", 32'(key_out), 32'h04);
    step(1);
    check("release2_out", 32'(key_out), 32'h0);
    check("release2_level", 32'(key_level), 32'h0);

    // bounce on channel 3: 3 low / 2 high, five times
    for (int r = 0; r < 5; r++) begin
      key_raw_n[3] = 1'b0;
      for (int k = 0; k < 3; k++) begin
        step(1);
        check("bounce3_out", 32'(key_out), 32'h0);
      end
      key_raw_n[3] = 1'b1;
      for (int k = 0; k < 2; k++) begin
        step(1);
        check("bounce3_level", 32'(key_level), 32'h0);
      end
    end
    step(8);
    check("bounce3_after", 32'(key_out | key_level), 32'h0);

    // auto-repeat on channel 0, channel 1 held alongside without repeat
    key_raw_n[1:0] = 2'b00;
    step(7);
    check("rep_accept_out", 32'(key_out), 32'h03);
    check("rep_accept_level", 32'(key_level), 32'h03);
    for (int k = 1; k <= 60; k++) begin
      step(1);
      exp_out = !((k == DLY) || (k > DLY && ((k - DLY) % PER) == 0));
      check("rep_out0", 32'(key_out[0]), 32'(exp_out));
      check("rep_level0", 32'(key_level[0]), 32'h1);
      check("rep_out1", 32'(key_out[1]), 32'h1);
    end
    key_raw_n[1:0] = 2'b11;
    step(10);
    check("rep_release", 32'(key_out | key_level), 32'h0);

    // reset in the middle of a hold
    key_raw_n[0] = 1'b0;
    step(7);
    check("rst_hold_out", 32'(key_out), 32'h01);
    step(3);
    reset_n = 1'b0;
    step(1);
    check("rst_drop_out", 32'(key_out), 32'h0);
    check("rst_drop_level", 32'(key_level), 32'h0);
    step(1);
    reset_n = 1'b1;
    step(6);
    check("rst_relatch_pre", 32'(key_out), 32'h0);
    step(1);
    check("rst_relatch_out", 32'(key_out), 32'h01);
    key_raw_n[0] = 1'b1;
    step(10);
    check("rst_release", 32'(key_out), 32'h0);

    // PIO integration: 40-cycle hold gives press edge plus two repeats
    ec_clr = 1'b1;
    step(1);
    ec_clr = 1'b0;
    sets = 0;
    key_raw_n[0] = 1'b0;
    for (int k = 0; k < 52; k++) begin
      step(1);
      if (k == 39) key_raw_n[0] = 1'b1;
      if (edge_capture[0]) begin
        sets++;
        ec_clr = 1'b1;
      end else begin
        ec_clr = 1'b0;
      end
    end
    ec_clr = 1'b0;
    check("pio_sets", 32'(sets), 32'd3);
    check("pio_final_out", 32'(key_out), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/key_debounce.md
# key_debounce

Front-end conditioner for the oscilloscope's front-panel keys. Synchronizes the raw active-low key inputs, debounces each channel independently, and optionally auto-repeats held keys. `key_out` drives the `in_port` of the downstream processor PIO, whose rising-edge capture raises the key interrupt. Auto-repeat therefore works by inserting one-cycle low gaps, so each gap yields a fresh rising edge at the PIO.

## Interface
- `WIDTH`, 5: number of key channels.
- `DEBOUNCE_CYCLES`, 500000: stable cycles required to accept a press or a release (10 ms at 50 MHz); minimum 2.
- `REPEAT_DELAY`, 25000000: held cycles before the first repeat gap; minimum 2.
- `REPEAT_PERIOD`, 5000000: cycles between successive repeat gaps; minimum 2.
- `REPEAT_MASK`, 5'b00011: per-channel auto-repeat enable (bit i = channel i).

Ports:
- `clk`  in  1  system clock; the same clock as the PIO.
- `reset_n`  in  1  reset; one clock; reset is synchronous and active-low.
- `key_raw_n`  in  WIDTH  raw board keys, asynchronous, 0 = pressed.
- `key_out`  out  WIDTH  debounced press level with repeat gaps; 1 = pressed; feeds the PIO `in_port`.
- `key_level`  out  WIDTH  debounced press level without repeat gaps.

## Operation
- **Synchronizer.** 2-flop synchronizer per bit on `~key_raw_n`, giving `sync[i]` (1 = pressed). Both flops reset to 0.
- **Per-channel FSM:** IDLE, PRESS_WAIT, HELD, GAP, RELEASE_WAIT. It uses a debounce counter `cnt` and a repeat counter `rep`.
- **IDLE**
  - `sync` = 1 → PRESS_WAIT with `cnt` = 0.
- **PRESS_WAIT**
  - `sync` = 0 → IDLE.
  - `cnt` = DEBOUNCE_CYCLES-1 → HELD with `rep` = 0.
  - Otherwise `cnt`++.
- **HELD**
  - `sync` = 0 → RELEASE_WAIT with `cnt` = 0; `rep` is frozen.
  - Otherwise `rep`++.
  - If REPEAT_MASK[i] is set and the repeat deadline is reached → GAP.
  - Deadline: REPEAT_DELAY cycles after first HELD entry, then REPEAT_PERIOD cycles after each GAP.
- **GAP** (exactly one cycle)
  - `sync` = 1 → HELD.
  - `sync` = 0 → RELEASE_WAIT with `cnt` = 0.
- **RELEASE_WAIT**
  - `sync` = 1 → HELD, resuming the frozen `rep`. A bounce does not restart the repeat schedule.
  - `cnt` = DEBOUNCE_CYCLES-1 → IDLE.
  - Otherwise `cnt`++.
- **Outputs** (registered, decoded from next state):
  - `key_level` = 1 in HELD, GAP and RELEASE_WAIT.
  - `key_out` = 1 in HELD and RELEASE_WAIT; 0 in GAP.
- **Widths.** `cnt` is $clog2(DEBOUNCE_CYCLES) bits. `rep` is $clog2(max(REPEAT_DELAY, REPEAT_PERIOD)) bits. Counters never wrap: they are held or reset at their terminal values.
- **Masked channel.** A channel with REPEAT_MASK[i] = 0 never enters GAP; `key_out` equals `key_level`.

## Timing
- Reset: all FSMs IDLE, counters 0, `key_out` = 0, `key_level` = 0, synchronizer 0.
- **Reset mid-operation.** Reset while a key is held drops both outputs to 0 on the next edge. After release of reset, the held key must re-debounce, producing a new rising edge after the full latency.
- Press latency: `key_out` rises DEBOUNCE_CYCLES+3 edges after the first edge that samples `key_raw_n` = 0.
- Release latency: `key_out` falls DEBOUNCE_CYCLES+3 edges after the first edge that samples `key_raw_n` = 1, provided no bounce occurs.
- Repeat pattern for a held key:
  - `key_out` high for REPEAT_DELAY cycles, then low 1 cycle.
  - Then high REPEAT_PERIOD-1 cycles, low 1 cycle, repeating.
- The 1-cycle gap is sufficient for the same-clock PIO edge detector.
- **Bounce.** Any `sync` toggle shorter than DEBOUNCE_CYCLES changes neither output.
- **Independence.** Channels are fully independent; simultaneous presses on all channels are each processed with identical latency.

## Structure
- Package `key_debounce_pkg`:
  - state enum `kd_state_t` {IDLE, PRESS_WAIT, HELD, GAP, RELEASE_WAIT};
  - counter-width helper function.
- Sub-module `key_debounce_chan`: synchronizer, FSM, counters and output registers for one channel; parameters DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD, REPEAT_EN.
- Top level instantiates WIDTH copies via generate.

## Test plan
Bench overrides: DEBOUNCE_CYCLES = 4, REPEAT_DELAY = 20, REPEAT_PERIOD = 8, REPEAT_MASK = 5'b00001.
- **Clean press.** `key_raw_n`[2] driven 0 and held → `key_out`[2] rises exactly 7 edges later. `key_level`[2] matches it; other bits stay 0.
- **Bounce rejection.** `key_raw_n`[3] pulses 0 for 3 cycles, 1 for 2 cycles, ×5 → `key_out`[3] stays 0.
- **Release bounce.** A 2-cycle 1-glitch during a hold on channel 2 → `key_out`[2] stays 1, with no rising edge.
- **Auto-repeat.** Channel 0 held 60 cycles after acceptance:
  - `key_out`[0] high 20 cycles, 0 for 1 cycle, then high 7 / low 1 repeating;
  - `key_level`[0] constant 1;
  - channel 1, held in parallel, shows no gaps.
- **Reset mid-hold.** `reset_n` = 0 for 2 cycles during a hold on channel 0 → outputs 0 on the next edge. `key_out`[0] rises again 7 edges after the first post-reset sample.
- **PIO integration.** Connect to the PIO model and hold channel 0 for 40 cycles → edge_capture[0] sets 3 times: one press edge plus 2 repeat edges.
